// File: rtl/breakout_link_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | breakout_link_scheduler                                                  |
// | Frame sequencer for the breakout-to-host DDR link, with a round-robin    |
// | side channel carried one bit per frame in o_frame_d0[9:8].               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module breakout_link_scheduler #(
   parameter int N_REQ        = 4,
   parameter int FRAME_CYCLES = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [7:0]           i_port,
   input  logic [5:0]           i_button,
   input  logic [3:0]           i_link_pow,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [8*N_REQ-1:0]   i_req_data,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic                 o_load,
   output logic [9:0]           o_frame_d0,
   output logic [9:0]           o_frame_d1,
   output logic                 o_busy
);

   localparam int              CNT_W      = $clog2(FRAME_CYCLES);
   localparam int              PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_edge = CNT_W'(FRAME_CYCLES - 2);
   localparam logic [3:0]       c_last_req = 4'(N_REQ - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bits_left;
   logic [11:0]      r_msg;
   logic [PTR_W-1:0] r_ptr;
   logic             r_load;
   logic [9:0]       r_d0;
   logic [9:0]       r_d1;
   logic             r_busy;

   logic             w_frame_edge;
   logic             w_free;
   logic             w_found;
   logic             w_xfer;
   logic [3:0]       w_grant;
   logic [7:0]       w_gdata;
   logic [N_REQ-1:0] w_onehot;
   int               w_idx;

   assign w_frame_edge = (r_cnt == c_cnt_edge);
   assign w_free       = (r_bits_left == 4'd0);
   assign w_xfer       = w_frame_edge & w_free & w_found;

   // Round-robin search starting at r_ptr; first valid requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_grant  = '0;
      w_gdata  = '0;
      w_onehot = '0;
      w_idx    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = int'(r_ptr) + i;
         if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
         if (!w_found && i_req_valid[w_idx]) begin
            w_found         = 1'b1;
            w_grant         = 4'(w_idx);
            w_gdata         = i_req_data[8*w_idx +: 8];
            w_onehot[w_idx] = 1'b1;
         end
      end
   end

   // Ready is gated by reset so requesters never see an accept during reset.
   assign o_req_ready = (i_rst_n && w_frame_edge && w_free) ? w_onehot : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_bits_left <= '0;
         r_msg       <= '0;
         r_ptr       <= '0;
         r_load      <= 1'b0;
         r_d0        <= '0;
         r_d1        <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
         r_load <= w_frame_edge;
         if (w_frame_edge) begin
            r_d1      <= {i_port, i_link_pow[3:2]};
            r_d0[7:0] <= {i_button, i_link_pow[1:0]};
            if (w_xfer) begin
               // Bit 11 goes out now; r_msg[10] is the next bit on the wire.
               r_msg       <= {w_grant, w_gdata};
               r_d0[9:8]   <= {1'b1, w_grant[3]};
               r_bits_left <= 4'd11;
               r_ptr       <= (w_grant == c_last_req) ? '0 : PTR_W'(w_grant + 4'd1);
               r_busy      <= 1'b1;
            end else if (!w_free) begin
               r_d0[9:8]   <= {1'b0, r_msg[10]};
               r_msg       <= {r_msg[10:0], 1'b0};
               r_bits_left <= r_bits_left - 4'd1;
               r_busy      <= 1'b1;
            end else begin
               r_d0[9:8]   <= 2'b00;
               r_busy      <= 1'b0;
            end
         end
      end
   end

   assign o_load     = r_load;
   assign o_frame_d0 = r_d0;
   assign o_frame_d1 = r_d1;
   assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/breakout_link_scheduler.md
# breakout_link_scheduler

Frame sequencer and side-channel arbiter for the breakout-to-host serial link. It generates the per-frame load strobe and the two 10-bit frame words consumed by the DDR serializer. It samples the port, button and link-power inputs once per frame. It also time-shares the two otherwise-unused d0 bits among N_REQ requesters, sending one 12-bit message bit per frame under round-robin arbitration.

## Interface
- N_REQ, 4: number of side-channel requesters; 1..16.
- FRAME_CYCLES, 5: i_clk cycles per frame; must be >= 3.

- i_clk  in  1  serializer word clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_port  in  8  digital port inputs.
- i_button  in  6  button inputs.
- i_link_pow  in  4  link power status.
- i_req_valid  in  N_REQ  per-requester message valid.
- i_req_data  in  8*N_REQ  payloads; requester k uses bits [8k+7:8k].
- o_req_ready  out  N_REQ  per-requester accept (combinational).
- o_load  out  1  one-cycle frame strobe, registered.
- o_frame_d0  out  10  {sc_start, sc_bit, button[5:0], link_pow[1:0]}, registered.
- o_frame_d1  out  10  {port[7:0], link_pow[3:2]}, registered.
- o_busy  out  1  high while o_frame_d0[9:8] carries a message bit, registered.

## Operation
- Frame counter cnt (0..FRAME_CYCLES-1) increments every cycle and wraps to 0.
- The frame edge is the rising edge that ends a cycle with cnt == FRAME_CYCLES-2. At that edge:
  - o_frame_d0 and o_frame_d1 reload from the current inputs and side-channel state.
  - o_load goes high for exactly one cycle, the cycle with cnt == FRAME_CYCLES-1.
- Words hold between frame edges. The consumer captures them while o_load is high.
- Side channel: bits_left counter (0..11), 12-bit shift register msg, round-robin pointer ptr.
- Channel free: bits_left == 0.
- Grant g: the first requester with i_req_valid set, searching ptr, ptr+1, … mod N_REQ.
- o_req_ready[g] = channel free AND cnt == FRAME_CYCLES-2 AND some valid. All other ready bits are 0.
  - The transfer happens at the frame edge where valid and ready are both high.
  - i_req_valid must not depend on o_req_ready.
  - i_req_valid may drop before it is granted; nothing is sent.
- On a transfer at a frame edge:
  - msg <= {g[3:0], data_g}.
  - o_frame_d0[9:8] <= {1, g[3]}.
  - bits_left <= 11.
  - ptr <= (g+1) mod N_REQ.
  - o_busy <= 1.
- Later frame edges with bits_left != 0: o_frame_d0[9:8] <= {0, next msg bit, MSB first}; bits_left decrements; o_busy <= 1.
- Frame edge, channel free, no valid: o_frame_d0[9:8] <= 00; o_busy <= 0.
- Back-to-back messages: a grant is possible at the frame edge right after the frame carrying bit 0, so there are no idle frames between messages.
- Message bit order: bits 11..8 are the requester id (zero-extended), bits 7..0 the payload MSB first. Only bit 11's frame has sc_start = 1.

## Timing
- Reset values (asynchronous, while i_rst_n = 0):
  - cnt = 0, bits_left = 0, ptr = 0, msg = 0.
  - o_load = 0, o_frame_d0 = 0, o_frame_d1 = 0, o_busy = 0.
  - o_req_ready = 0, forced low while in reset.
- After release, cycles are numbered from 0. The first o_load is in cycle FRAME_CYCLES-1, then every FRAME_CYCLES cycles.
- Input-to-word latency: an input value present before a frame edge appears on the words immediately after it. There is no other synchronization; inputs are already in the i_clk domain.
- A message occupies exactly 12 consecutive frames.
- Reset mid-message abandons it; no resumption. The host sees sc_start = 0 frames until the next grant.
- Simultaneous free slot and several valids resolve by ptr only. The payload is captured at the transfer edge; later payload changes have no effect.

## Test plan
- Reset, FRAME_CYCLES=5, all inputs 0 -> o_load high in cycles 4, 9, 14; all words 0; o_busy 0; ready all 0.
- i_port changes 0x00 -> 0xFF one cycle before a frame edge -> o_frame_d1 = 0x3FC (link_pow = 0) in the o_load cycle that follows.
- Requester 2 only, data 0xA5 -> ready[2] high exactly one cycle; the next 12 frames carry d0[9:8] = 10, 00, 01, 00, 01, 00, 01, 00, 00, 01, 00, 01 (msg 0x2A5); o_busy high for 60 cycles.
- All four valid continuously -> grants 0, 1, 2, 3, 0 with start frames 12 frames apart and no idle frame between.
- Requester 1 raises valid in the cycle after its ready window -> not granted until the next frame edge, 5 cycles later.
- i_rst_n pulsed low mid-message (after the bit-5 frame) -> all outputs 0 immediately; after release ptr = 0; d0[9:8] = 00 until a new grant; the first o_load again comes in cycle 4.
